psk_stream_mapper: RTL and testbench

- Bit-serial, multi-mode PSK mapper for the SDR transmit chain. It is the parametrised successor of the fixed 8-PSK register-mapper.
- Collects 1/2/3 input bits per symbol according to a mode select, maps them Gray-coded to BPSK/QPSK/8-PSK I/Q points, and presents them on a valid/ready stream toward the pulse-shaping filter.
- Amplitude and output width are parameters.

---
 rtl/psk_stream_mapper.sv | 206 ++++++++++++++++++++
 tb/tb_psk_stream_mapper.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/psk_stream_mapper.sv
// psk_stream_mapper: bit-serial BPSK/QPSK/8-PSK Gray mapper with a
// valid/ready symbol output and one pending-symbol slot.
// Optional feature macro: PSK_PI4_QPSK_EN (pi/4-alternating QPSK, adds pi4_en).
//
// Handshake: a bit moves when bit_valid && bit_ready; a symbol moves when
// sym_valid && sym_ready. bit_ready depends only on registered state, and
// i_out/q_out stay stable while sym_valid && !sym_ready.
module psk_stream_mapper #(
  parameter int OUT_W = 4,
  parameter int AMP   = 2,
  parameter int DIAG  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic             bit_in,
  input  logic             bit_valid,
`ifdef PSK_PI4_QPSK_EN
  input  logic             pi4_en,
`endif
  output logic             bit_ready,
  output logic [OUT_W-1:0] i_out,
  output logic [OUT_W-1:0] q_out,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic             mode_err
);

  localparam logic [OUT_W-1:0] P_A  = OUT_W'(AMP);
  localparam logic [OUT_W-1:0] N_A  = OUT_W'(-AMP);
  localparam logic [OUT_W-1:0] P_D  = OUT_W'(DIAG);
  localparam logic [OUT_W-1:0] N_D  = OUT_W'(-DIAG);
  localparam logic [OUT_W-1:0] ZERO = '0;

  // Gray-coded constellation lookup; rot selects the on-axis QPSK set.
  function automatic logic [2*OUT_W-1:0] psk_map(input logic [1:0] m,
                                                 input logic [2:0] b,
                                                 input logic       rot);
    logic [2*OUT_W-1:0] r;
    r = {ZERO, ZERO};
    case (m)
      2'd0: r = b[0] ? {N_A, ZERO} : {P_A, ZERO};
      2'd1: begin
        if (rot) begin
          case (b[1:0])
            2'b00:   r = {P_A, ZERO};
            2'b01:   r = {ZERO, P_A};
            2'b11:   r = {N_A, ZERO};
            default: r = {ZERO, N_A};
          endcase
        end else begin
          case (b[1:0])
            2'b00:   r = {P_D, P_D};
            2'b01:   r = {N_D, P_D};
            2'b11:   r = {N_D, N_D};
            default: r = {P_D, N_D};
          endcase
        end
      end
      2'd2: begin
        case (b)
          3'b000:  r = {P_A, ZERO};
          3'b001:  r = {P_D, P_D};
          3'b011:  r = {ZERO, P_A};
          3'b010:  r = {N_D, P_D};
          3'b110:  r = {N_A, ZERO};
          3'b111:  r = {N_D, N_D};
          3'b101:  r = {ZERO, N_A};
          default: r = {P_D, N_D};
        endcase
      end
      default: r = {ZERO, ZERO};
    endcase
    return r;
  endfunction

  logic [1:0]       count_q, count_d;
  logic [1:0]       shift_q, shift_d;
  logic [1:0]       mode_q, mode_d;
  logic             pend_q, pend_d;
  logic [2:0]       pend_bits_q, pend_bits_d;
  logic [1:0]       pend_mode_q, pend_mode_d;
  logic [OUT_W-1:0] i_q, i_d, q_q, q_d;
  logic             valid_q, valid_d;
  logic             err_q;
  logic             rot_q, rot_d;
  logic             pi4_on;

`ifdef PSK_PI4_QPSK_EN
  assign pi4_on = pi4_en;
`else
  assign pi4_on = 1'b0;
`endif

  logic             bit_fire, sym_fire, out_free, complete, load;
  logic [1:0]       cur_mode, n_bits, ld_mode;
  logic [2:0]       sym_bits, ld_bits;
  logic [2*OUT_W-1:0] mapped;

  assign bit_ready = !pend_q;
  assign bit_fire  = bit_valid && bit_ready && !clear;
  assign sym_fire  = valid_q && sym_ready;
  assign out_free  = !valid_q || sym_ready;
  // Mode is sampled on the first bit of a symbol and held until it completes.
  assign cur_mode  = (count_q == 2'd0) ? mode : mode_q;
  assign n_bits    = (cur_mode == 2'd0) ? 2'd1 : (cur_mode == 2'd1) ? 2'd2 : 2'd3;
  assign sym_bits  = {shift_q, bit_in};
  assign complete  = bit_fire && ((count_q + 2'd1) == n_bits);

  // Next-state for collector, pending slot and output register.
  always_comb begin
    count_d     = count_q;
    shift_d     = shift_q;
    mode_d      = mode_q;
    pend_d      = pend_q;
    pend_bits_d = pend_bits_q;
    pend_mode_d = pend_mode_q;
    i_d         = i_q;
    q_d         = q_q;
    valid_d     = valid_q;
    rot_d       = rot_q;
    load        = 1'b0;
    ld_bits     = sym_bits;
    ld_mode     = cur_mode;
    if (bit_fire) begin
      if (complete) begin
        count_d = 2'd0;
        shift_d = 2'b00;
      end else begin
        count_d = count_q + 2'd1;
        shift_d = {shift_q[0], bit_in};
        mode_d  = cur_mode;
      end
    end
    if (pend_q && sym_fire) begin
      load    = 1'b1;
      ld_bits = pend_bits_q;
      ld_mode = pend_mode_q;
      pend_d  = 1'b0;
    end else if (complete && out_free) begin
      load = 1'b1;
    end else if (complete) begin
      pend_d      = 1'b1;
      pend_bits_d = sym_bits;
      pend_mode_d = cur_mode;
    end else if (sym_fire) begin
      valid_d = 1'b0;
    end
    mapped = psk_map(ld_mode, ld_bits, pi4_on && rot_q);
    if (load) begin
      i_d     = mapped[2*OUT_W-1:OUT_W];
      q_d     = mapped[OUT_W-1:0];
      valid_d = 1'b1;
      if (pi4_on && ld_mode == 2'd1) rot_d = !rot_q;
    end
    if (clear) begin
      count_d = 2'd0;
      shift_d = 2'b00;
      pend_d  = 1'b0;
      i_d     = '0;
      q_d     = '0;
      valid_d = 1'b0;
      rot_d   = 1'b0;
    end
  end

  // Datapath and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= 2'd0;
      shift_q     <= 2'b00;
      mode_q      <= 2'd0;
      pend_q      <= 1'b0;
      pend_bits_q <= 3'b000;
      pend_mode_q <= 2'd0;
      i_q         <= '0;
      q_q         <= '0;
      valid_q     <= 1'b0;
      rot_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      shift_q     <= shift_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      pend_bits_q <= pend_bits_d;
      pend_mode_q <= pend_mode_d;
      i_q         <= i_d;
      q_q         <= q_d;
      valid_q     <= valid_d;
      rot_q       <= rot_d;
    end
  end

  // Sticky reserved-mode flag; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (complete && cur_mode == 2'd3) err_q <= 1'b1;
  end

  assign i_out     = i_q;
  assign q_out     = q_q;
  assign sym_valid = valid_q;
  assign mode_err  = err_q;

endmodule

// File: tb/tb_psk_stream_mapper.sv
// Directed bench for psk_stream_mapper (OUT_W=4, AMP=2, DIAG=1).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_psk_stream_mapper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
`ifdef PSK_PI4_QPSK_EN
  logic       pi4_en = 1'b0;
`endif
  logic       bit_ready;
  logic [3:0] i_out, q_out;
  logic       sym_valid;
  logic       sym_ready = 1'b0;
  logic       mode_err;

  int n_cmp = 0;
  int n_err = 0;

  psk_stream_mapper #(.OUT_W(4), .AMP(2), .DIAG(1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode),
    .bit_in(bit_in), .bit_valid(bit_valid),
`ifdef PSK_PI4_QPSK_EN
    .pi4_en(pi4_en),
`endif
    .bit_ready(bit_ready), .i_out(i_out), .q_out(q_out),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_sym(input string tag, input int ei, input int eq);
    check({tag, ".valid"}, {31'd0, sym_valid}, 1);
    check({tag, ".i"}, $signed(i_out), ei);
    check({tag, ".q"}, $signed(q_out), eq);
  endtask

  // Present one bit for a single cycle; returns on the next falling edge.
  task automatic send_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst.valid", {31'd0, sym_valid}, 0);
    check("rst.i", $signed(i_out), 0);
    check("rst.q", $signed(q_out), 0);
    check("rst.err", {31'd0, mode_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.bit_ready", {31'd0, bit_ready}, 1);

    // 8PSK 001 -> (1,1), then 110 -> (-2,0)
    mode = 2'd2; sym_ready = 1'b1;
    send_bit(1'b0); send_bit(1'b0);
    check("8psk001.valid_early", {31'd0, sym_valid}, 0);
    send_bit(1'b1);
    check_sym("8psk001", 1, 1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check_sym("8psk110", -2, 0);
    @(negedge clk);
    check("8psk.drained", {31'd0, sym_valid}, 0);

    // QPSK with backpressure: 01 -> (-1,1) held, 11 pending, 10 pending
    mode = 2'd1; sym_ready = 1'b0;
    send_bit(1'b0); send_bit(1'b1);
    check_sym("qpsk01", -1, 1);
    send_bit(1'b1); send_bit(1'b1);
    check_sym("qpsk01.held", -1, 1);
    check("qpsk.pend_ready", {31'd0, bit_ready}, 0);
    sym_ready = 1'b1;
    @(negedge clk);
    sym_ready = 1'b0;
    check_sym("qpsk11", -1, -1);
    check("qpsk.ready_back", {31'd0, bit_ready}, 1);
    send_bit(1'b1); send_bit(1'b0);
    check_sym("qpsk11.held", -1, -1);
    check("qpsk.pend_ready2", {31'd0, bit_ready}, 0);
    sym_ready = 1'b1;
    @(negedge clk);
    check_sym("qpsk10", 1, -1);
    @(negedge clk);
    check("qpsk.drained", {31'd0, sym_valid}, 0);

    // BPSK continuous 1,0,1
    mode = 2'd0;
    bit_valid = 1'b1; bit_in = 1'b1;
    @(negedge clk);
    check_sym("bpsk1a", -2, 0);
    check("bpsk.ready_a", {31'd0, bit_ready}, 1);
    bit_in = 1'b0;
    @(negedge clk);
    check_sym("bpsk0", 2, 0);
    check("bpsk.ready_b", {31'd0, bit_ready}, 1);
    bit_in = 1'b1;
    @(negedge clk);
    check_sym("bpsk1b", -2, 0);
    bit_valid = 1'b0;
    @(negedge clk);

    // Mode change mid-symbol: 8PSK 101 -> (0,-2), then BPSK 0 -> (2,0)
    mode = 2'd2;
    send_bit(1'b1);
    mode = 2'd0;
    send_bit(1'b0);
    check("latch.valid_mid", {31'd0, sym_valid}, 0);
    send_bit(1'b1);
    check_sym("latch.8psk101", 0, -2);
    send_bit(1'b0);
    check_sym("latch.bpsk0", 2, 0);
    @(negedge clk);

    // Reserved mode, sticky error, clear mid-symbol, then reset
    mode = 2'd3; sym_ready = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check_sym("mode3", 0, 0);
    check("mode3.err", {31'd0, mode_err}, 1);
    send_bit(1'b1);
    clear = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    @(negedge clk);
    clear = 1'b0; bit_valid = 1'b0;
    check("clear.valid", {31'd0, sym_valid}, 0);
    check("clear.i", $signed(i_out), 0);
    check("clear.err", {31'd0, mode_err}, 1);
    check("clear.ready", {31'd0, bit_ready}, 1);
    mode = 2'd0;
    send_bit(1'b1);
    check_sym("clear.bpsk_after", -2, 0);
    rst_n = 1'b0;
    #1;
    check("rst2.valid", {31'd0, sym_valid}, 0);
    check("rst2.i", $signed(i_out), 0);
    check("rst2.q", $signed(q_out), 0);
    check("rst2.err", {31'd0, mode_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst2.ready", {31'd0, bit_ready}, 1);

`ifdef PSK_PI4_QPSK_EN
    // pi/4 QPSK: 00,00,00 -> (1,1), (2,0), (1,1)
    pi4_en = 1'b1; mode = 2'd1; sym_ready = 1'b1;
    send_bit(1'b0); send_bit(1'b0);
    check_sym("pi4.a", 1, 1);
    send_bit(1'b0); send_bit(1'b0);
    check_sym("pi4.b", 2, 0);
    send_bit(1'b0); send_bit(1'b0);
    check_sym("pi4.c", 1, 1);
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
